// File: rtl/montacargas_n.sv
// montacargas_n: N-floor freight-elevator controller.
// Homes the cabin to floor 0 after reset, latches call buttons into a
// pending-request register and serves them in SCAN order (keep direction
// while requests remain ahead, then reverse). Holds the door open for a
// timed interval and traps endstop/travel faults in a sticky FAULT state.
// Every output is a register; o_dbg_state exposes the FSM state.
module montacargas_n #(
    parameter int FLOORS       = 4,
    parameter int DOOR_TICKS   = 8,
    parameter int MOVE_TIMEOUT = 50,
    parameter int FW           = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] btn,
    input  logic [FLOORS-1:0] endstop,
    output logic [1:0]        motor,
    output logic [FW-1:0]     floor_idx,
    output logic [6:0]        disp_7seg,
    output logic [FLOORS-1:0] pending,
    output logic              door_open,
    output logic              fault,
    output logic [2:0]        o_dbg_state
);

    localparam int DCW = $clog2(DOOR_TICKS + 1);
    localparam int MCW = $clog2(MOVE_TIMEOUT + 1);

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b01;
    localparam logic [1:0] MOTOR_DOWN = 2'b10;

    typedef enum logic [2:0] {
        S_HOME  = 3'd0,
        S_IDLE  = 3'd1,
        S_UP    = 3'd2,
        S_DOWN  = 3'd3,
        S_DOOR  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t             r_state;
    logic [1:0]         r_motor;
    logic [FW-1:0]      r_floor;
    logic [6:0]         r_disp;
    logic [FLOORS-1:0]  r_pending;
    logic               r_door;
    logic               r_fault;
    logic               r_last_dir;   // 1 = up, 0 = down
    logic [DCW-1:0]     r_door_cnt;
    logic [MCW-1:0]     r_move_cnt;

    logic               w_multi;
    logic               w_any;
    logic [FW-1:0]      w_k;
    logic [FLOORS-1:0]  w_floor_mask;
    logic               w_btn_here;
    logic               w_arrive;
    logic               w_hit;
    logic               w_above;
    logic               w_below;
    logic               w_go_up;
    logic               w_go_down;
    logic               w_moving;
    logic               w_progress;
    logic               w_timeout;
    logic [FLOORS-1:0]  w_latch_move;
    logic [FLOORS-1:0]  w_latch_stopped;

    // 7-segment {g,f,e,d,c,b,a} pattern for digits 1..9
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // Endstop decode, current-floor mask and requests above/below the cabin
    always_comb begin
        w_k          = '0;
        w_floor_mask = '0;
        w_above      = 1'b0;
        w_below      = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (endstop[i]) w_k = FW'(i);
            if (FW'(i) == r_floor) w_floor_mask[i] = 1'b1;
            if (r_pending[i] && (FW'(i) > r_floor)) w_above = 1'b1;
            if (r_pending[i] && (FW'(i) < r_floor)) w_below = 1'b1;
        end
    end

    // Several endstops at once is physically impossible: treat as fault
    assign w_multi    = |(endstop & (endstop - FLOORS'(1)));
    assign w_any      = |endstop;
    assign w_arrive   = w_any && !w_multi && (w_k != r_floor);
    assign w_hit      = |(r_pending & endstop);
    assign w_btn_here = |(btn & w_floor_mask);

    // SCAN: keep the last direction while requests lie ahead
    assign w_go_up   = r_last_dir ? w_above : (!w_below && w_above);
    assign w_go_down = r_last_dir ? (!w_above && w_below) : w_below;

    // A press at the floor the cabin stands at opens the door instead of latching
    assign w_latch_move    = r_pending | btn;
    assign w_latch_stopped = r_pending | (btn & ~w_floor_mask);

    // Travel watchdog: motor on without reaching a fresh endstop
    assign w_moving   = (r_motor != MOTOR_STOP);
    assign w_progress = (((r_state == S_UP) || (r_state == S_DOWN)) && w_arrive) ||
                        ((r_state == S_HOME) && endstop[0] && !w_multi);
    assign w_timeout  = w_moving && !w_progress &&
                        (r_move_cnt == MCW'(MOVE_TIMEOUT - 1));

    // Main controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HOME;
            r_motor    <= MOTOR_STOP;
            r_floor    <= '0;
            r_disp     <= 7'b0000110;
            r_pending  <= '0;
            r_door     <= 1'b0;
            r_fault    <= 1'b0;
            r_last_dir <= 1'b1;
            r_door_cnt <= '0;
            r_move_cnt <= '0;
        end else begin
            r_disp <= seg_decode(4'(r_floor) + 4'd1);
            if (!w_moving || w_progress) r_move_cnt <= '0;
            else                         r_move_cnt <= r_move_cnt + 1'b1;

            if (w_multi || w_timeout) begin
                r_state <= S_FAULT;
                r_motor <= MOTOR_STOP;
                r_door  <= 1'b0;
                r_fault <= 1'b1;
            end else begin
                case (r_state)
                    S_HOME: begin
                        r_pending <= '0;
                        if (endstop[0]) begin
                            r_state <= S_IDLE;
                            r_motor <= MOTOR_STOP;
                            r_floor <= '0;
                        end else begin
                            r_motor <= MOTOR_DOWN;
                        end
                    end
                    S_IDLE: begin
                        r_pending <= w_latch_stopped;
                        if (w_btn_here) begin
                            r_state    <= S_DOOR;
                            r_door     <= 1'b1;
                            r_door_cnt <= '0;
                        end else if (w_go_up) begin
                            r_state    <= S_UP;
                            r_last_dir <= 1'b1;
                            r_motor    <= MOTOR_UP;
                        end else if (w_go_down) begin
                            r_state    <= S_DOWN;
                            r_last_dir <= 1'b0;
                            r_motor    <= MOTOR_DOWN;
                        end
                    end
                    S_UP, S_DOWN: begin
                        r_pending <= w_latch_move;
                        if (w_arrive) begin
                            r_floor <= w_k;
                            if (w_hit) begin
                                r_pending  <= w_latch_move & ~endstop;
                                r_motor    <= MOTOR_STOP;
                                r_door     <= 1'b1;
                                r_door_cnt <= '0;
                                r_state    <= S_DOOR;
                            end else if (((r_state == S_UP) && (w_k == FW'(FLOORS - 1))) ||
                                         ((r_state == S_DOWN) && (w_k == '0))) begin
                                r_motor <= MOTOR_STOP;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_DOOR: begin
                        r_pending <= w_latch_stopped;
                        r_motor   <= MOTOR_STOP;
                        if (w_btn_here) begin
                            r_door_cnt <= '0;
                        end else if (r_door_cnt == DCW'(DOOR_TICKS - 1)) begin
                            r_door     <= 1'b0;
                            r_door_cnt <= '0;
                            if (w_go_up) begin
                                r_state    <= S_UP;
                                r_last_dir <= 1'b1;
                                r_motor    <= MOTOR_UP;
                            end else if (w_go_down) begin
                                r_state    <= S_DOWN;
                                r_last_dir <= 1'b0;
                                r_motor    <= MOTOR_DOWN;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_door_cnt <= r_door_cnt + 1'b1;
                        end
                    end
                    S_FAULT: begin
                        r_motor <= MOTOR_STOP;
                        r_door  <= 1'b0;
                        r_fault <= 1'b1;
                    end
                    default: r_state <= S_HOME;
                endcase
            end
        end
    end

    assign motor       = r_motor;
    assign floor_idx   = r_floor;
    assign disp_7seg   = r_disp;
    assign pending     = r_pending;
    assign door_open   = r_door;
    assign fault       = r_fault;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_montacargas_n.sv
// Bench for montacargas_n: a shaft plant turns the motor into endstop
// pulses; a SCAN reference model predicts the stop order for each batch of
// calls and a scoreboard queue holds the expected floors.
module tb_montacargas_n;

    localparam int F   = 4;
    localparam int DT  = 8;
    localparam int MT  = 50;
    localparam int S   = 3;          // plant steps between floors
    localparam int FWB = $clog2(F);

    logic           clk;
    logic           rst;
    logic [F-1:0]   btn;
    logic [F-1:0]   endstop;
    logic [1:0]     motor;
    logic [FWB-1:0] floor_idx;
    logic [6:0]     disp_7seg;
    logic [F-1:0]   pending;
    logic           door_open;
    logic           fault;
    logic [2:0]     dbg_state;

    int checks   = 0;
    int failures = 0;

    int           p;            // cabin position in plant steps
    bit           ovr_en;
    logic [F-1:0] ovr_val;
    int           cur_floor;
    bit           cur_dir;      // 1 = up
    logic [FWB-1:0] exp_q[$];
    logic [6:0]   seg_tab [0:8];

    montacargas_n #(.FLOORS(F), .DOOR_TICKS(DT), .MOVE_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .btn(btn), .endstop(endstop),
        .motor(motor), .floor_idx(floor_idx), .disp_7seg(disp_7seg),
        .pending(pending), .door_open(door_open), .fault(fault),
        .o_dbg_state(dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [F-1:0] dec(input int pos);
        dec = '0;
        if (pos >= 0 && (pos % S) == 0 && (pos / S) < F) dec[pos / S] = 1'b1;
    endfunction

    // shaft plant: one step per clock in the commanded direction
    initial begin
        p       = 10;
        ovr_en  = 1'b0;
        ovr_val = '0;
        endstop = dec(p);
        forever begin
            @(posedge clk);
            #2;
            if (motor == 2'b01 && p < (F - 1) * S) p++;
            else if (motor == 2'b10 && p > 0)      p--;
            endstop = ovr_en ? ovr_val : dec(p);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fail_to(input string tag);
        checks++;
        failures++;
        $error("FAIL %s timeout got=none exp=event", tag);
    endtask

    task automatic home();
        int start, cnt;
        bit done;
        rst = 1'b1;
        btn = '0;
        @(negedge clk);
        check("rst_motor", motor, 2'b00);
        check("rst_pending", pending, '0);
        check("rst_floor", floor_idx, '0);
        check("rst_door", door_open, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_disp", disp_7seg, seg_tab[0]);
        @(negedge clk);
        rst   = 1'b0;
        start = p;
        cnt   = 0;
        done  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (motor == 2'b10) cnt++;
            else if (motor == 2'b00 && floor_idx == '0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_to("home");
        else begin
            check("home_cycles", cnt, start);
            check("home_pending", pending, '0);
            check("home_disp", disp_7seg, seg_tab[0]);
        end
        cur_floor = 0;
        cur_dir   = 1'b1;
    endtask

    // press a batch of calls while stopped and follow the predicted stops
    task automatic serve(input logic [F-1:0] mask, input bit hold, input int press_at);
        logic [FWB-1:0] above_q[$], below_q[$];
        logic [F-1:0]   remaining;
        int prev, tgt, n, pa;
        bit ok;
        for (int f = cur_floor + 1; f < F; f++) if (mask[f]) above_q.push_back(FWB'(f));
        for (int f = cur_floor - 1; f >= 0; f--) if (mask[f]) below_q.push_back(FWB'(f));
        if (cur_dir) begin
            exp_q = {above_q, below_q};
            if (below_q.size() > 0) cur_dir = 1'b0;
        end else begin
            exp_q = {below_q, above_q};
            if (above_q.size() > 0) cur_dir = 1'b1;
        end
        @(negedge clk);
        btn = mask;
        @(negedge clk);
        if (!hold) btn = '0;
        check("pend_latch", pending, mask);
        remaining = mask;
        prev      = cur_floor;
        pa        = press_at;
        while (exp_q.size() > 0) begin
            tgt = int'(exp_q.pop_front());
            ok  = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (motor != 2'b00) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) fail_to("depart");
            else check("dir", motor, (tgt > prev) ? 2'b01 : 2'b10);
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (door_open) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) fail_to("arrive");
            else begin
                remaining[tgt] = 1'b0;
                check("stop_floor", floor_idx, tgt);
                check("stop_motor", motor, 2'b00);
                check("stop_pending", pending, remaining);
                n = 0;
                for (int i = 0; i < 60; i++) begin
                    if (!door_open) break;
                    btn = '0;
                    n++;
                    if (n == pa) btn[tgt] = 1'b1;
                    @(negedge clk);
                end
                btn = '0;
                check("door_len", n, (pa > 0) ? pa + DT : DT);
                check("door_pending", pending, remaining);
            end
            pa   = 0;
            prev = tgt;
        end
        check("rest_motor", motor, 2'b00);
        check("rest_floor", floor_idx, prev);
        check("rest_disp", disp_7seg, seg_tab[prev]);
        cur_floor = prev;
    endtask

    task automatic idle_press();
        int n;
        @(negedge clk);
        btn = '0;
        btn[cur_floor] = 1'b1;
        @(negedge clk);
        btn = '0;
        check("idle_door", door_open, 1'b1);
        check("idle_pending", pending, '0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (door_open) n++;
            else break;
        end
        check("idle_door_len", n, DT);
        check("idle_motor", motor, 2'b00);
    endtask

    task automatic wait_motor_on(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (motor != 2'b00) begin ok = 1'b1; break; end
        end
    endtask

    // main sequence
    initial begin
        logic [F-1:0] mask, frozen;
        bit ok;
        seg_tab[0] = 7'b0000110; seg_tab[1] = 7'b1011011; seg_tab[2] = 7'b1001111;
        seg_tab[3] = 7'b1100110; seg_tab[4] = 7'b1101101; seg_tab[5] = 7'b1111101;
        seg_tab[6] = 7'b0000111; seg_tab[7] = 7'b1111111; seg_tab[8] = 7'b1101111;
        rst = 1'b1;
        btn = '0;
        repeat (2) @(negedge clk);

        // homing from above the top floor
        home();

        // single call with held button and a same-floor press at door cycle 5
        serve(4'b0100, 1'b1, 5);
        idle_press();
        // SCAN walk: 2->0, 0->1, then {0,2,3} from floor 1 going up
        serve(4'b0001, 1'b0, 0);
        serve(4'b0010, 1'b0, 0);
        serve(4'b1101, 1'b0, 0);

        // randomized batches
        for (int r = 0; r < 8; r++) begin
            mask = F'($urandom_range(1, (1 << F) - 1));
            mask[cur_floor] = 1'b0;
            if (mask == '0) mask = (cur_floor == 0) ? 4'b0010 : 4'b0001;
            serve(mask, 1'b0, 0);
        end

        // double endstop while moving
        mask = '0;
        mask[(cur_floor < 2) ? F - 1 : 0] = 1'b1;
        @(negedge clk);
        btn = mask;
        @(negedge clk);
        btn = '0;
        wait_motor_on(ok);
        if (!ok) fail_to("fault_depart");
        ovr_val = 4'b0011;
        ovr_en  = 1'b1;
        @(negedge clk);
        check("pre_fault", fault, 1'b0);
        @(negedge clk);
        check("multi_fault", fault, 1'b1);
        check("multi_motor", motor, 2'b00);
        check("multi_door", door_open, 1'b0);
        check("multi_pending", pending, mask);
        frozen = pending;
        btn = ~mask;
        repeat (2) @(negedge clk);
        btn = '0;
        @(negedge clk);
        check("fault_btn_ignored", pending, frozen);
        check("fault_sticky", fault, 1'b1);
        ovr_en = 1'b0;
        home();

        // reset in the middle of a move
        @(negedge clk);
        btn = 4'b1000;
        @(negedge clk);
        btn = '0;
        wait_motor_on(ok);
        if (!ok) fail_to("mid_depart");
        else check("mid_motor", motor, 2'b01);
        @(negedge clk);
        home();

        // travel timeout: endstops stay dark while homing
        ovr_val = '0;
        ovr_en  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (motor == 2'b10) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("to_motor");
        repeat (MT - 3) @(negedge clk);
        check("to_early", fault, 1'b0);
        repeat (5) @(negedge clk);
        check("to_fault", fault, 1'b1);
        check("to_motor_off", motor, 2'b00);
        btn = 4'b0110;
        repeat (2) @(negedge clk);
        btn = '0;
        check("to_btn_ignored", pending, '0);
        ovr_en = 1'b0;
        home();
        check("final_fault", fault, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
